// File: rtl/hci_arb_policy_ctrl_pkg.sv
// Shared types and constants for the HCI arbitration-policy controller.
package hci_arb_policy_ctrl_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    BOOST  = 2'd1,
    GUARD  = 2'd2
  } hci_arbctl_state_e;

  // Value of the crossbar policy select that gives the core group (CH0) priority.
  localparam logic HCI_ARB_CH0_PRIO = 1'b0;

endpackage

// File: rtl/hci_arb_policy_ctrl_if.sv
// Monitored requester handshakes of both channel groups plus the policy driven back to the crossbar.
// req/gnt: a requester is served in a cycle where req and gnt are both high; req high with gnt low is a stall.
interface hci_arb_policy_ctrl_if #(
    parameter int unsigned N_CH0 = 16,
    parameter int unsigned N_CH1 = 4
);
    logic [N_CH0-1:0] ch0_req;
    logic [N_CH0-1:0] ch0_gnt;
    logic [N_CH1-1:0] ch1_req;
    logic [N_CH1-1:0] ch1_gnt;
    logic             prio;
    logic             boost;

    modport master (
        output ch0_req, ch0_gnt, ch1_req, ch1_gnt,
        input  prio, boost
    );

    modport slave (
        input  ch0_req, ch0_gnt, ch1_req, ch1_gnt,
        output prio, boost
    );
endinterface

// File: rtl/hci_arb_policy_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module hci_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/hci_arb_policy_ctrl.sv
// Dynamic CH0/CH1 priority controller: static policy, inverted for a bounded window when
// the low-priority group starves, followed by a guard interval before counting resumes.
module hci_arb_policy_ctrl
    import hci_arb_policy_ctrl_pkg::*;
#(
    parameter int unsigned N_CH0        = 16,
    parameter int unsigned N_CH1        = 4,
    parameter int unsigned CW           = 8,
    parameter int unsigned EW           = 16,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 cfg_prio_i,
    input  logic [CW-1:0]        cfg_max_stall_i,
    input  logic [CW-1:0]        cfg_boost_len_i,
    hci_arb_policy_ctrl_if.slave bus,
    output logic [CW-1:0]        stall_cnt_o,
    output logic [EW-1:0]        boost_events_o,
    output hci_arbctl_state_e    state_o
);

    localparam logic [CW:0] GUARD_LIM = (CW+1)'(GUARD_CYCLES);

    hci_arbctl_state_e state_q;
    logic              prio_q, boost_q, prio_cfg_q;
    logic [CW-1:0]     stall_cnt, boost_cnt, guard_cnt;

    logic ch0_stall, ch0_prog, ch0_any, ch1_stall, ch1_prog, ch1_any;
    logic lp_stall, lp_prog, lp_any, starved;
    logic prio_chg, flush, boost_hit, boost_done, guard_done;
    logic [CW-1:0] boost_len_eff;
    logic [CW:0]   stall_p1, boost_p1, guard_p1;
    logic stall_clr, stall_inc, boost_clr, boost_inc, guard_clr, guard_inc, ev_clr, ev_inc;

    assign ch0_stall = |(bus.ch0_req & ~bus.ch0_gnt);
    assign ch0_prog  = |(bus.ch0_req &  bus.ch0_gnt);
    assign ch0_any   = |bus.ch0_req;
    assign ch1_stall = |(bus.ch1_req & ~bus.ch1_gnt);
    assign ch1_prog  = |(bus.ch1_req &  bus.ch1_gnt);
    assign ch1_any   = |bus.ch1_req;

    // The monitored group is whichever one currently lacks priority.
    always_comb begin
        lp_stall = ch1_stall;
        lp_prog  = ch1_prog;
        lp_any   = ch1_any;
        if (cfg_prio_i != HCI_ARB_CH0_PRIO) begin
            lp_stall = ch0_stall;
            lp_prog  = ch0_prog;
            lp_any   = ch0_any;
        end
    end

    assign starved       = lp_stall & ~lp_prog;
    assign prio_chg      = cfg_prio_i != prio_cfg_q;
    assign flush         = clear_i | ~enable_i | prio_chg;
    assign boost_len_eff = (cfg_boost_len_i == '0) ? CW'(1) : cfg_boost_len_i;
    assign stall_p1      = {1'b0, stall_cnt} + (CW+1)'(1);
    assign boost_p1      = {1'b0, boost_cnt} + (CW+1)'(1);
    assign guard_p1      = {1'b0, guard_cnt} + (CW+1)'(1);
    assign boost_hit     = (cfg_max_stall_i != '0) && starved && (stall_p1 >= {1'b0, cfg_max_stall_i});
    assign boost_done    = (boost_p1 >= {1'b0, boost_len_eff}) || !lp_any;
    assign guard_done    = guard_p1 >= GUARD_LIM;

    always_comb begin
        stall_inc = 1'b0;
        boost_inc = 1'b0;
        guard_inc = 1'b0;
        stall_clr = 1'b1;
        boost_clr = 1'b1;
        guard_clr = 1'b1;
        ev_clr    = clear_i;
        ev_inc    = 1'b0;
        if (!flush) begin
            unique case (state_q)
                NORMAL: begin
                    stall_clr = !starved || boost_hit;
                    stall_inc = starved;
                    ev_inc    = boost_hit;
                end
                BOOST: begin
                    boost_clr = boost_done;
                    boost_inc = 1'b1;
                end
                GUARD: begin
                    guard_clr = guard_done;
                    guard_inc = 1'b1;
                end
                default: ;
            endcase
        end
    end

    hci_sat_counter #(.W(CW)) u_stall_cnt (.clk_i, .rst_ni, .clr_i(stall_clr), .inc_i(stall_inc), .cnt_o(stall_cnt));
    hci_sat_counter #(.W(CW)) u_boost_cnt (.clk_i, .rst_ni, .clr_i(boost_clr), .inc_i(boost_inc), .cnt_o(boost_cnt));
    hci_sat_counter #(.W(CW)) u_guard_cnt (.clk_i, .rst_ni, .clr_i(guard_clr), .inc_i(guard_inc), .cnt_o(guard_cnt));
    hci_sat_counter #(.W(EW)) u_boost_evt (.clk_i, .rst_ni, .clr_i(ev_clr), .inc_i(ev_inc), .cnt_o(boost_events_o));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= NORMAL;
            prio_q     <= 1'b0;
            boost_q    <= 1'b0;
            prio_cfg_q <= 1'b0;
        end else begin
            prio_cfg_q <= cfg_prio_i;
            if (flush) begin
                state_q <= NORMAL;
                prio_q  <= cfg_prio_i;
                boost_q <= 1'b0;
            end else begin
                unique case (state_q)
                    NORMAL: begin
                        prio_q <= cfg_prio_i;
                        if (boost_hit) begin
                            state_q <= BOOST;
                            prio_q  <= ~cfg_prio_i;
                            boost_q <= 1'b1;
                        end
                    end
                    BOOST: begin
                        prio_q <= ~cfg_prio_i;
                        if (boost_done) begin
                            state_q <= GUARD;
                            prio_q  <= cfg_prio_i;
                            boost_q <= 1'b0;
                        end
                    end
                    GUARD: begin
                        prio_q <= cfg_prio_i;
                        if (guard_done) state_q <= NORMAL;
                    end
                    default: begin
                        state_q <= NORMAL;
                        prio_q  <= cfg_prio_i;
                        boost_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.prio    = prio_q;
    assign bus.boost   = boost_q;
    assign stall_cnt_o = stall_cnt;
    assign state_o     = state_q;

endmodule

// File: tb/tb_hci_arb_policy_ctrl.sv
// Directed bench for hci_arb_policy_ctrl: a default instance plus an EW=2 instance for event saturation.
module tb_hci_arb_policy_ctrl;
    import hci_arb_policy_ctrl_pkg::*;

    localparam int N_CH0 = 16;
    localparam int N_CH1 = 4;
    localparam int CW    = 8;

    logic clk_i = 1'b0;
    logic rst_ni, clear_i, enable_i, cfg_prio_i;
    logic [CW-1:0] cfg_max_stall_i, cfg_boost_len_i;
    logic [N_CH0-1:0] ch0_req, ch0_gnt;
    logic [N_CH1-1:0] ch1_req, ch1_gnt;

    logic [CW-1:0]     stall_cnt_a, stall_cnt_b;
    logic [15:0]       events_a;
    logic [1:0]        events_b;
    hci_arbctl_state_e state_a, state_b;

    int tests_run = 0;
    int failed    = 0;

    always #5 clk_i = ~clk_i;

    hci_arb_policy_ctrl_if #(.N_CH0(N_CH0), .N_CH1(N_CH1)) bus_a ();
    hci_arb_policy_ctrl_if #(.N_CH0(N_CH0), .N_CH1(N_CH1)) bus_b ();

    assign bus_a.ch0_req = ch0_req;
    assign bus_a.ch0_gnt = ch0_gnt;
    assign bus_a.ch1_req = ch1_req;
    assign bus_a.ch1_gnt = ch1_gnt;
    assign bus_b.ch0_req = ch0_req;
    assign bus_b.ch0_gnt = ch0_gnt;
    assign bus_b.ch1_req = ch1_req;
    assign bus_b.ch1_gnt = ch1_gnt;

    hci_arb_policy_ctrl #(.N_CH0(N_CH0), .N_CH1(N_CH1), .CW(CW), .EW(16), .GUARD_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
        .cfg_prio_i(cfg_prio_i), .cfg_max_stall_i(cfg_max_stall_i), .cfg_boost_len_i(cfg_boost_len_i),
        .bus(bus_a.slave), .stall_cnt_o(stall_cnt_a), .boost_events_o(events_a), .state_o(state_a)
    );

    hci_arb_policy_ctrl #(.N_CH0(N_CH0), .N_CH1(N_CH1), .CW(CW), .EW(2), .GUARD_CYCLES(4)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
        .cfg_prio_i(cfg_prio_i), .cfg_max_stall_i(cfg_max_stall_i), .cfg_boost_len_i(cfg_boost_len_i),
        .bus(bus_b.slave), .stall_cnt_o(stall_cnt_b), .boost_events_o(events_b), .state_o(state_b)
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni          = 1'b0;
        clear_i         = 1'b0;
        enable_i        = 1'b1;
        cfg_prio_i      = 1'b0;
        cfg_max_stall_i = '0;
        cfg_boost_len_i = '0;
        ch0_req = '0; ch0_gnt = '0; ch1_req = '0; ch1_gnt = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++; if (bus_a.prio !== 1'b0) begin failed++; $display("FAIL reset_prio got=%0b exp=0", bus_a.prio); end
        tests_run++; if (bus_a.boost !== 1'b0) begin failed++; $display("FAIL reset_boost got=%0b exp=0", bus_a.boost); end
        tests_run++; if (stall_cnt_a !== 8'd0) begin failed++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt_a); end
        tests_run++; if (events_a !== 16'd0) begin failed++; $display("FAIL reset_events got=%0d exp=0", events_a); end
        tests_run++; if (state_a !== NORMAL) begin failed++; $display("FAIL reset_state got=%0d exp=%0d", state_a, NORMAL); end
    endtask

    task automatic test_static_policy();
        int bad;
        apply_reset();
        cfg_max_stall_i = 8'd0;
        cfg_boost_len_i = 8'd3;
        ch1_req = 4'hF;
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (bus_a.prio !== 1'b0 || bus_a.boost !== 1'b0) bad++;
        end
        tests_run++; if (bad !== 0) begin failed++; $display("FAIL static_no_boost bad_cycles=%0d exp=0", bad); end
        tests_run++; if (events_a !== 16'd0) begin failed++; $display("FAIL static_events got=%0d exp=0", events_a); end
    endtask

    task automatic test_starvation_boost();
        apply_reset();
        cfg_max_stall_i = 8'd5;
        cfg_boost_len_i = 8'd3;
        ch1_req = 4'b0001;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k <= 4) begin
                tests_run++; if (stall_cnt_a !== CW'(k)) begin failed++; $display("FAIL boost_stall_cnt k=%0d got=%0d exp=%0d", k, stall_cnt_a, k); end
                tests_run++; if (bus_a.prio !== 1'b0) begin failed++; $display("FAIL boost_pre_prio k=%0d got=%0b exp=0", k, bus_a.prio); end
            end else if (k <= 7) begin
                tests_run++; if (bus_a.prio !== 1'b1 || bus_a.boost !== 1'b1) begin failed++; $display("FAIL boost_window k=%0d got prio=%0b boost=%0b exp 1/1", k, bus_a.prio, bus_a.boost); end
                tests_run++; if (state_a !== BOOST) begin failed++; $display("FAIL boost_state k=%0d got=%0d exp=%0d", k, state_a, BOOST); end
            end else if (k <= 11) begin
                tests_run++; if (state_a !== GUARD) begin failed++; $display("FAIL guard_state k=%0d got=%0d exp=%0d", k, state_a, GUARD); end
                tests_run++; if (bus_a.prio !== 1'b0 || bus_a.boost !== 1'b0 || stall_cnt_a !== 8'd0) begin failed++; $display("FAIL guard_outputs k=%0d got prio=%0b boost=%0b stall=%0d exp 0/0/0", k, bus_a.prio, bus_a.boost, stall_cnt_a); end
            end else if (k <= 16) begin
                tests_run++; if (state_a !== NORMAL || bus_a.prio !== 1'b0) begin failed++; $display("FAIL reboost_wait k=%0d got state=%0d prio=%0b exp NORMAL/0", k, state_a, bus_a.prio); end
                tests_run++; if (stall_cnt_a !== CW'(k-12)) begin failed++; $display("FAIL reboost_stall k=%0d got=%0d exp=%0d", k, stall_cnt_a, k-12); end
            end else begin
                tests_run++; if (bus_a.prio !== 1'b1 || state_a !== BOOST) begin failed++; $display("FAIL reboost k=%0d got prio=%0b state=%0d exp 1/BOOST", k, bus_a.prio, state_a); end
            end
            if (k == 11) begin
                tests_run++; if (events_a !== 16'd1) begin failed++; $display("FAIL boost_events_one got=%0d exp=1", events_a); end
            end
        end
        tests_run++; if (events_a !== 16'd2) begin failed++; $display("FAIL boost_events_two got=%0d exp=2", events_a); end
    endtask

    task automatic test_early_exit();
        apply_reset();
        cfg_max_stall_i = 8'd2;
        cfg_boost_len_i = 8'd10;
        ch1_req = 4'b0100;
        tick(); tick();
        tests_run++; if (state_a !== BOOST) begin failed++; $display("FAIL early_enter got=%0d exp=%0d", state_a, BOOST); end
        tick();
        ch1_req = '0;
        tick();
        tests_run++; if (bus_a.prio !== 1'b0 || bus_a.boost !== 1'b0) begin failed++; $display("FAIL early_exit_out got prio=%0b boost=%0b exp 0/0", bus_a.prio, bus_a.boost); end
        tests_run++; if (state_a !== GUARD) begin failed++; $display("FAIL early_exit_state got=%0d exp=%0d", state_a, GUARD); end
        // Length expiry and loss of requests in the same cycle: a single exit.
        apply_reset();
        cfg_max_stall_i = 8'd1;
        cfg_boost_len_i = 8'd0;
        ch1_req = 4'b1000;
        tick();
        tests_run++; if (state_a !== BOOST || stall_cnt_a !== 8'd0) begin failed++; $display("FAIL max_stall_one got state=%0d stall=%0d exp BOOST/0", state_a, stall_cnt_a); end
        ch1_req = '0;
        tick();
        tests_run++; if (state_a !== GUARD || events_a !== 16'd1) begin failed++; $display("FAIL simul_exit got state=%0d events=%0d exp GUARD/1", state_a, events_a); end
        repeat (4) tick();
        tests_run++; if (state_a !== NORMAL) begin failed++; $display("FAIL guard_len got=%0d exp=%0d", state_a, NORMAL); end
    endtask

    task automatic test_progress_resets();
        apply_reset();
        cfg_max_stall_i = 8'd5;
        cfg_boost_len_i = 8'd3;
        ch1_req = 4'b0011;
        repeat (4) tick();
        tests_run++; if (stall_cnt_a !== 8'd4) begin failed++; $display("FAIL prog_pre got=%0d exp=4", stall_cnt_a); end
        ch1_gnt = 4'b0001;
        tick();
        tests_run++; if (stall_cnt_a !== 8'd0) begin failed++; $display("FAIL prog_clear got=%0d exp=0", stall_cnt_a); end
        ch1_gnt = '0;
        repeat (4) tick();
        tests_run++; if (stall_cnt_a !== 8'd4 || state_a !== NORMAL || bus_a.prio !== 1'b0) begin failed++; $display("FAIL prog_no_boost got stall=%0d state=%0d prio=%0b exp 4/NORMAL/0", stall_cnt_a, state_a, bus_a.prio); end
        tick();
        tests_run++; if (state_a !== BOOST) begin failed++; $display("FAIL prog_threshold got=%0d exp=%0d", state_a, BOOST); end
    endtask

    task automatic test_cfg_change();
        apply_reset();
        cfg_max_stall_i = 8'd2;
        cfg_boost_len_i = 8'd10;
        ch1_req = 4'b0010;
        tick(); tick();
        tests_run++; if (state_a !== BOOST || bus_a.prio !== 1'b1) begin failed++; $display("FAIL cfg_pre_boost got state=%0d prio=%0b exp BOOST/1", state_a, bus_a.prio); end
        cfg_prio_i = 1'b1;
        ch0_req    = 16'h0100;
        tick();
        tests_run++; if (bus_a.prio !== 1'b1 || bus_a.boost !== 1'b0 || state_a !== NORMAL) begin failed++; $display("FAIL cfg_toggle got prio=%0b boost=%0b state=%0d exp 1/0/NORMAL", bus_a.prio, bus_a.boost, state_a); end
        tick();
        tests_run++; if (stall_cnt_a !== 8'd1) begin failed++; $display("FAIL cfg_ch0_monitored got=%0d exp=1", stall_cnt_a); end
        tick();
        tests_run++; if (bus_a.prio !== 1'b0 || bus_a.boost !== 1'b1) begin failed++; $display("FAIL cfg_ch0_boost got prio=%0b boost=%0b exp 0/1", bus_a.prio, bus_a.boost); end
        enable_i = 1'b0;
        tick();
        tests_run++; if (bus_a.prio !== 1'b1 || bus_a.boost !== 1'b0 || state_a !== NORMAL) begin failed++; $display("FAIL disable got prio=%0b boost=%0b state=%0d exp 1/0/NORMAL", bus_a.prio, bus_a.boost, state_a); end
        repeat (5) tick();
        tests_run++; if (bus_a.boost !== 1'b0 || stall_cnt_a !== 8'd0) begin failed++; $display("FAIL disable_hold got boost=%0b stall=%0d exp 0/0", bus_a.boost, stall_cnt_a); end
        tests_run++; if (events_a !== 16'd2) begin failed++; $display("FAIL disable_events got=%0d exp=2", events_a); end
    endtask

    task automatic test_reset_mid_boost();
        apply_reset();
        cfg_max_stall_i = 8'd1;
        cfg_boost_len_i = 8'd20;
        ch1_req = 4'b0001;
        tick(); tick();
        tests_run++; if (bus_a.boost !== 1'b1) begin failed++; $display("FAIL rst_pre_boost got=%0b exp=1", bus_a.boost); end
        #2;
        rst_ni = 1'b0;
        #1;
        tests_run++; if (bus_a.prio !== 1'b0 || bus_a.boost !== 1'b0) begin failed++; $display("FAIL async_reset got prio=%0b boost=%0b exp 0/0", bus_a.prio, bus_a.boost); end
        tests_run++; if (state_a !== NORMAL || events_a !== 16'd0) begin failed++; $display("FAIL async_reset_state got state=%0d events=%0d exp NORMAL/0", state_a, events_a); end
    endtask

    task automatic test_saturation();
        apply_reset();
        cfg_max_stall_i = 8'd1;
        cfg_boost_len_i = 8'd1;
        ch1_req = 4'b0001;
        repeat (26) tick();
        tests_run++; if (events_a !== 16'd5) begin failed++; $display("FAIL sat_wide got=%0d exp=5", events_a); end
        tests_run++; if (events_b !== 2'd3) begin failed++; $display("FAIL sat_narrow got=%0d exp=3", events_b); end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tests_run++; if (events_a !== 16'd0 || events_b !== 2'd0) begin failed++; $display("FAIL clear_events got a=%0d b=%0d exp 0/0", events_a, events_b); end
        tests_run++; if (state_a !== NORMAL || stall_cnt_a !== 8'd0) begin failed++; $display("FAIL clear_state got state=%0d stall=%0d exp NORMAL/0", state_a, stall_cnt_a); end
    endtask

    initial begin
        test_reset();
        test_static_policy();
        test_starvation_boost();
        test_early_exit();
        test_progress_resets();
        test_cfg_change();
        test_reset_mid_boost();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/hci_arb_policy_ctrl.md
Name: hci_arb_policy_ctrl

Overview:
- Dynamic arbitration-policy controller for the HCI logarithmic interconnect. Drives the channel-priority select (ctrl.arb_policy) between the CH0 (core) and CH1 (accelerator) requester groups of the TCDM crossbar.
- Normally holds a static, configured priority.
- When the low-priority group starves for a configured number of consecutive cycles, it inverts priority for a bounded boost window, then applies a guard interval before starvation counting resumes.
- Sits beside the interconnect, fed by the per-requester req/gnt of both channel groups.

Parameters:
N_CH0, 16, number of CH0 requesters
N_CH1, 4, number of CH1 requesters
CW, 8, width of stall/boost counters and their config fields
EW, 16, width of boost event counter
GUARD_CYCLES, 4, cycles in GUARD state (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  sync clear: FSM to NORMAL, all counters 0
enable_i  in  1  0 = static policy only
cfg_prio_i  in  1  static priority: 0 = CH0 high, 1 = CH1 high
cfg_max_stall_i  in  CW  starvation threshold in cycles; 0 disables boosting
cfg_boost_len_i  in  CW  boost window length in cycles; 0 treated as 1
ch0_req_i  in  N_CH0  CH0 requests
ch0_gnt_i  in  N_CH0  CH0 grants
ch1_req_i  in  N_CH1  CH1 requests
ch1_gnt_i  in  N_CH1  CH1 grants
prio_o  out  1  registered arbitration policy to the crossbar
boost_o  out  1  registered, 1 while in BOOST
stall_cnt_o  out  CW  current starvation counter
boost_events_o  out  EW  saturating count of BOOST entries

Behaviour:
- Reset: FSM = NORMAL; all outputs 0; all counters 0.
- Low-priority group: CH1 when cfg_prio_i = 0, CH0 when cfg_prio_i = 1.
- lp_stall = OR over the low-priority group of (req & ~gnt).
- lp_prog = OR over the low-priority group of (req & gnt).
- lp_any = OR over the low-priority group of req.

NORMAL state:
- prio_o <= cfg_prio_i.
- If lp_stall & ~lp_prog, stall_cnt increments, saturating at all-ones. Otherwise stall_cnt clears to 0.
- Transition to BOOST when: cfg_max_stall_i != 0, lp_stall & ~lp_prog this cycle, and stall_cnt + 1 >= cfg_max_stall_i.
- On that transition: prio_o <= ~cfg_prio_i, boost_o <= 1, boost_events increments (saturating), stall_cnt <= 0.
- The first inverted-priority cycle is therefore exactly cfg_max_stall_i cycles after the first starved cycle.

BOOST state:
- prio_o held at ~cfg_prio_i; boost_cnt increments each cycle.
- Exit to GUARD when either condition holds:
  - boost_cnt + 1 >= max(cfg_boost_len_i, 1), or
  - lp_any = 0 (starvation resolved).
- On exit: prio_o <= cfg_prio_i, boost_o <= 0, boost_cnt <= 0.

GUARD state:
- prio_o = cfg_prio_i; stall counting suspended (stall_cnt held at 0).
- Returns to NORMAL after GUARD_CYCLES cycles.

Priority and boundary rules:
- Precedence: rst_ni > clear_i > ~enable_i > cfg_prio_i change > normal FSM.
- enable_i = 0: forced NORMAL; counters cleared; prio_o <= cfg_prio_i next cycle.
- cfg_prio_i change, detected against a registered copy:
  - Any state returns to NORMAL with counters cleared.
  - prio_o follows the new value next cycle.
- cfg_max_stall_i = 1: BOOST is entered after a single starved cycle.
- Simultaneous boost-length expiry and lp_any = 0: one exit to GUARD, no double counting.
- boost_events saturates at 2^EW-1; it is reset only by rst_ni or clear_i.
- Config inputs are sampled every cycle. Changing the threshold mid-count takes effect on the next comparison.
- Asynchronous reset mid-BOOST: outputs return to 0 immediately.

Decomposition:
- hci_package gains:
  - typedef hci_arbctl_state_e {NORMAL, BOOST, GUARD};
  - constant HCI_ARB_CH0_PRIO = 1'b0.
- One sub-module, hci_sat_counter (parameterised width: inc, clr, saturating). Instantiated for stall_cnt, boost_cnt, guard_cnt and boost_events.
- The FSM and group reduction logic stay in the top.

Test Plan:
1. Static policy: cfg_prio = 0, enable = 1, max_stall = 0; CH1 stalled for 100 cycles -> prio_o stays 0, boost_o never 1, boost_events = 0.
2. Starvation boost: cfg_prio = 0, max_stall = 5, boost_len = 3; ch1_req = 1, ch1_gnt = 0 from cycle 0 ->
   - stall_cnt_o counts 1..4;
   - prio_o = 1 and boost_o = 1 for cycles 5..7;
   - GUARD for 4 cycles;
   - boost_events = 1;
   - re-boost at earliest 5 cycles after GUARD ends.
3. Early exit: in BOOST, drop all ch1_req after 1 cycle with boost_len = 10 -> prio_o returns to 0 at the next edge; state = GUARD.
4. Progress resets count: stall 4 cycles, one grant to any CH1 requester, stall 4 more with max_stall = 5 -> no boost; stall_cnt_o returns to 0 after the grant.
5. Config change and disable:
   - Toggle cfg_prio_i from 0 to 1 mid-BOOST -> next cycle prio_o = 1, boost_o = 0, state NORMAL, CH0 is now the monitored group.
   - enable_i = 0 -> same result.
6. Reset and saturation:
   - Assert rst_ni low mid-BOOST -> prio_o and boost_o = 0 immediately.
   - With EW = 2, force 5 boosts -> boost_events_o = 3.
   - clear_i -> boost_events_o = 0.
